tlc_sensor_controller: RTL and testbench

Parametrised, sensor-actuated traffic light controller for a highway/farm-road intersection, successor to the fixed-cycle controller. Timing limits are parameters. A farm-road vehicle sensor drives the sequence: the highway rests green and the farm road gets green only on demand, extended while traffic is present. It sits between board I/O (sensor input, LED outputs, debug header) and the system clock.

---
 rtl/tlc_sensor_controller.sv | 137 +++++++++++++
 tb/tb_tlc_sensor_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tlc_sensor_controller.sv
// Sensor-actuated highway/farm-road traffic light controller with a saturating dwell counter.
// Define TLC_PED_EN to add the PedReq input and the Walk output.
module tlc_sensor_controller #(
  parameter int CNT_W    = 31,
  parameter int HWY_MIN  = 1500000000,
  parameter int YEL_T    = 300000000,
  parameter int AR_T     = 100000000,
  parameter int FARM_MIN = 300000000,
  parameter int FARM_MAX = 1500000000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       FarmSensor,
`ifdef TLC_PED_EN
  input  logic       PedReq,
  output logic       Walk,
`endif
  output logic [1:0] highwaySignal,
  output logic [1:0] farmSignal,
  output logic [2:0] state,
  output logic       RstCount
);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  if (CNT_W < 1 || CNT_W > 62 ||
      HWY_MIN < 1 || longint'(HWY_MIN) > CNT_MAX ||
      YEL_T < 1 || longint'(YEL_T) > CNT_MAX ||
      AR_T < 1 || longint'(AR_T) > CNT_MAX ||
      FARM_MIN < 1 || longint'(FARM_MIN) > CNT_MAX ||
      FARM_MAX < 1 || longint'(FARM_MAX) > CNT_MAX ||
      FARM_MIN > FARM_MAX) begin : g_bad_params
    $error("tlc_sensor_controller: illegal dwell parameters");
  end

  localparam logic [CNT_W-1:0] HWY_LAST  = CNT_W'(HWY_MIN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YEL_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(AR_T - 1);
  localparam logic [CNT_W-1:0] FMIN_LAST = CNT_W'(FARM_MIN - 1);
  localparam logic [CNT_W-1:0] FMAX_LAST = CNT_W'(FARM_MAX - 1);

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  typedef enum logic [2:0] {
    HG  = 3'b000,
    HY  = 3'b001,
    AR1 = 3'b010,
    FG  = 3'b011,
    FY  = 3'b100,
    AR2 = 3'b101
  } st_e;

  st_e              st_q;
  st_e              nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sens_sync;
  logic             sens;
  logic             req;
  logic             req_set;
  logic             rst_count;

  assign sens = sens_sync[1];

`ifdef TLC_PED_EN
  logic [1:0] ped_sync;
  assign req_set = sens | ped_sync[1];
  assign Walk    = (st_q == FG) && (cnt <= FMIN_LAST);
`else
  assign req_set = sens;
`endif

  always_comb begin
    nxt       = st_q;
    rst_count = 1'b0;
    case (st_q)
      HG:  if (cnt >= HWY_LAST && (req || sens)) begin nxt = HY;  rst_count = 1'b1; end
      HY:  if (cnt == YEL_LAST)                  begin nxt = AR1; rst_count = 1'b1; end
      AR1: if (cnt == AR_LAST)                   begin nxt = FG;  rst_count = 1'b1; end
      FG:  if (cnt == FMAX_LAST || (cnt >= FMIN_LAST && !sens)) begin
             nxt       = FY;
             rst_count = 1'b1;
           end
      FY:  if (cnt == YEL_LAST)                  begin nxt = AR2; rst_count = 1'b1; end
      AR2: if (cnt == AR_LAST)                   begin nxt = HG;  rst_count = 1'b1; end
      default: begin
        nxt       = AR2;
        rst_count = 1'b1;
      end
    endcase
  end

  always_comb begin
    highwaySignal = RED;
    farmSignal    = RED;
    case (st_q)
      HG:      highwaySignal = GREEN;
      HY:      highwaySignal = YELLOW;
      FG:      farmSignal    = GREEN;
      FY:      farmSignal    = YELLOW;
      default: ;
    endcase
  end

  assign state    = st_q;
  assign RstCount = rst_count;

  // req follows the pre-edge state: a set during HG survives the exit edge,
  // and any set landing on FG entry is cleared by the first FG edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      st_q      <= AR2;
      cnt       <= '0;
      req       <= 1'b0;
      sens_sync <= '0;
`ifdef TLC_PED_EN
      ped_sync  <= '0;
`endif
    end else begin
      st_q      <= nxt;
      sens_sync <= {sens_sync[0], FarmSensor};
`ifdef TLC_PED_EN
      ped_sync  <= {ped_sync[0], PedReq};
`endif
      if (rst_count)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + CNT_W'(1);
      if (st_q == FG)
        req <= 1'b0;
      else if (req_set)
        req <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tlc_sensor_controller.sv
// Directed self-checking bench for tlc_sensor_controller using the small test parameters.
module tb_tlc_sensor_controller;

  localparam logic [2:0] S_HG  = 3'd0;
  localparam logic [2:0] S_HY  = 3'd1;
  localparam logic [2:0] S_AR1 = 3'd2;
  localparam logic [2:0] S_FG  = 3'd3;
  localparam logic [2:0] S_FY  = 3'd4;
  localparam logic [2:0] S_AR2 = 3'd5;

  logic       Clk;
  logic       Rst_n;
  logic       FarmSensor;
  logic [1:0] highwaySignal;
  logic [1:0] farmSignal;
  logic [2:0] state;
  logic       RstCount;
`ifdef TLC_PED_EN
  logic       PedReq;
  logic       Walk;
`endif

  int checks = 0;
  int errors = 0;

  tlc_sensor_controller #(
    .CNT_W   (5),
    .HWY_MIN (8),
    .YEL_T   (3),
    .AR_T    (2),
    .FARM_MIN(4),
    .FARM_MAX(10)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .FarmSensor   (FarmSensor),
`ifdef TLC_PED_EN
    .PedReq       (PedReq),
    .Walk         (Walk),
`endif
    .highwaySignal(highwaySignal),
    .farmSignal   (farmSignal),
    .state        (state),
    .RstCount     (RstCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // {highwaySignal, farmSignal} expected in each state
  function automatic int lights(input logic [2:0] s);
    case (s)
      S_HG:    return 4'b0010;
      S_HY:    return 4'b0110;
      S_FG:    return 4'b1000;
      S_FY:    return 4'b1001;
      default: return 4'b1010;
    endcase
  endfunction

  // Counts cycles spent in state s, optionally raising/dropping the sensor at given cycle indices.
  task automatic dwell(input logic [2:0] s, input int set_at, input int clr_at,
                       input string tag, input int exp_n);
    int n     = 0;
    int rc_hi = 0;
    check({tag, " lights"}, {highwaySignal, farmSignal}, lights(s));
    while (state == s && n < 200) begin
      if (RstCount) rc_hi++;
      if (n == set_at) FarmSensor = 1'b1;
      if (n == clr_at) FarmSensor = 1'b0;
      n++;
      @(negedge Clk);
    end
    check(tag, n, exp_n);
    check({tag, " rstcount"}, rc_hi, 1);
  endtask

  task automatic tail_from_hy(input string tag, input int fg_len);
    dwell(S_HY,  -1, -1, {tag, " hy"},  3);
    dwell(S_AR1, -1, -1, {tag, " ar1"}, 2);
    dwell(S_FG,  -1, -1, {tag, " fg"},  fg_len);
    dwell(S_FY,  -1, -1, {tag, " fy"},  3);
    dwell(S_AR2, -1, -1, {tag, " ar2"}, 2);
  endtask

  initial begin
    Rst_n      = 1'b0;
    FarmSensor = 1'b0;
`ifdef TLC_PED_EN
    PedReq     = 1'b0;
`endif
    repeat (3) @(negedge Clk);
    check("reset state", state, S_AR2);
    check("reset lights", {highwaySignal, farmSignal}, 4'b1010);
    check("reset rstcount", RstCount, 0);
`ifdef TLC_PED_EN
    check("reset walk", Walk, 0);
`endif

    // Boot: AR2 for 2 cycles, then HG held with no demand; counter saturates
    Rst_n = 1'b1;
    dwell(S_AR2, -1, -1, "boot ar2", 2);
    check("boot hg lights", {highwaySignal, farmSignal}, 4'b0010);
    repeat (100) @(negedge Clk);
    check("idle hg held", state, S_HG);
    check("idle rstcount", RstCount, 0);

    // Demand after 100 idle cycles: saturated count allows immediate exit
    FarmSensor = 1'b1;
    @(negedge Clk);
    FarmSensor = 1'b0;
    @(negedge Clk);
    check("sat exit state", state, S_HG);
    check("sat exit rstcount", RstCount, 1);
    @(negedge Clk);
    check("sat exit hy", state, S_HY);
    tail_from_hy("sat", 4);

    // One-cycle pulse at HG count 2: latch holds demand until count 7
    dwell(S_HG, 2, 3, "pulse hg", 8);
    tail_from_hy("pulse", 4);

    // Sensor held high: FG capped at FARM_MAX, next HG still full minimum
    dwell(S_HG, 0, -1, "hold hg", 8);
    tail_from_hy("hold", 10);
    dwell(S_HG, -1, -1, "hold next hg", 8);
    dwell(S_HY, -1, 0, "drop hy", 3);
    dwell(S_AR1, -1, -1, "drop ar1", 2);
    dwell(S_FG, -1, -1, "drop fg", 4);
    dwell(S_FY, -1, -1, "drop fy", 3);
    dwell(S_AR2, -1, -1, "drop ar2", 2);

    // Sensor released at FG count 6: seen low at count 8, FG lasts 9
    dwell(S_HG, 0, -1, "rel hg", 8);
    dwell(S_HY, -1, -1, "rel hy", 3);
    dwell(S_AR1, -1, -1, "rel ar1", 2);
    dwell(S_FG, -1, 6, "rel fg", 9);
    dwell(S_FY, -1, -1, "rel fy", 3);
    dwell(S_AR2, -1, -1, "rel ar2", 2);
    repeat (20) @(negedge Clk);
    check("req cleared hg held", state, S_HG);

    // Asynchronous reset at FG count 5
    FarmSensor = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    check("arst pre rstcount", RstCount, 1);
    @(negedge Clk);
    dwell(S_HY, -1, -1, "arst hy", 3);
    dwell(S_AR1, -1, -1, "arst ar1", 2);
    check("arst fg entry", state, S_FG);
    repeat (5) @(negedge Clk);
    check("arst fg c5", state, S_FG);
    #2;
    Rst_n = 1'b0;
    #1;
    check("arst state", state, S_AR2);
    check("arst lights", {highwaySignal, farmSignal}, 4'b1010);
    check("arst rstcount", RstCount, 0);
    FarmSensor = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    dwell(S_AR2, -1, -1, "arst ar2", 2);
    check("arst hg lights", {highwaySignal, farmSignal}, 4'b0010);

`ifdef TLC_PED_EN
    begin
      int w_in  = 0;
      int w_out = 0;
      int guard = 0;
      repeat (10) @(negedge Clk);
      PedReq = 1'b1;
      @(negedge Clk);
      PedReq = 1'b0;
      while (state != S_FG && guard < 60) begin
        if (Walk) w_out++;
        guard++;
        @(negedge Clk);
      end
      check("ped reached fg", state, S_FG);
      while (state == S_FG && guard < 120) begin
        if (Walk) w_in++;
        guard++;
        @(negedge Clk);
      end
      repeat (10) begin
        if (Walk) w_out++;
        @(negedge Clk);
      end
      check("ped walk in fg", w_in, 4);
      check("ped walk outside fg", w_out, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
